// File: rtl/zjh_disp_pkg.sv
// Shared types, constants and segment table for the seven-segment scan controller.
package zjh_disp_pkg;

  localparam int NDIG = 4;
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [3:0] Y_OFF   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    BLNK = 2'd2
  } state_e;

  typedef logic [NDIG-1:0][3:0] digits_t;

  // Segment patterns {a,b,c,d,e,f,g}, indexed by nibble (entry 0 is the LSB slice).
  localparam logic [15:0][6:0] HEX7_TBL = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,  // F E d C
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,  // b A 9 8
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,  // 7 6 5 4
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110   // 3 2 1 0
  };

  // Digit k (k>=1) is a leading zero when it and every more significant digit are 0.
  function automatic logic [NDIG-1:0] lz_mask(input digits_t d);
    logic run_zero;
    lz_mask  = '0;
    run_zero = 1'b1;
    for (int k = NDIG - 1; k >= 1; k--) begin
      run_zero   = run_zero & (d[k] == 4'd0);
      lz_mask[k] = run_zero;
    end
  endfunction

endpackage

// File: rtl/zjh_hex7seg.sv
// Combinational hex nibble to seven-segment decoder.
module zjh_hex7seg
  import zjh_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX7_TBL[nibble];

endmodule

// File: rtl/zjh_scan_ctrl.sv
// Four-digit seven-segment scan controller with prescaler, inter-digit blanking,
// frame-synchronous digit updates and leading-zero blanking. All outputs registered.
module zjh_scan_ctrl
  import zjh_disp_pkg::*;
#(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 2
) (
  input  logic       Clock,
  input  logic       Aclr,
  input  logic       en,
  input  logic       lz_blank,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] Y,
  output logic [6:0] seg,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
  localparam logic [15:0] BLANK_LAST = (BLANK == 0) ? 16'd0 : 16'(BLANK - 1);
  localparam bit          HAS_BLANK  = (BLANK != 0);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   cnt_q, cnt_d;
  digits_t       shadow_q, shadow_d;
  digits_t       active_q, active_d;
  logic          pending_q, pending_d;
  logic [3:0]    y_q, y_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    didx_q, didx_d;
  logic          tick_q, tick_d;
  logic          ready_q, ready_d;

  logic          wr_fire, commit;
  logic [NDIG-1:0] blank_mask;
  logic [6:0]    hex_seg;

  // Next-state sequencing.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the block infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = IDLE;
      idx_d   = 2'd0;
      cnt_d   = 16'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = SCAN;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
        end
        SCAN: begin
          if (cnt_q == DIV_LAST) begin
            cnt_d = 16'd0;
            if (HAS_BLANK) state_d = BLNK;
            else           idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        BLNK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SCAN;
            idx_d   = idx_q + 2'd1;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  // Write port and frame-boundary commit. A commit leaving IDLE may coincide with a
  // write; the commit takes the pre-write shadow and the new write stays pending.
  always_comb begin
    wr_fire  = wr_valid & ready_q;
    commit   = en & pending_q & (tick_q | (state_q == IDLE));
    active_d = commit ? shadow_q : active_q;
    shadow_d = shadow_q;
    if (wr_fire) shadow_d[wr_addr] = wr_data;
    pending_d = wr_fire | (pending_q & ~commit);
  end

  zjh_hex7seg u_hex7seg (
    .nibble (active_d[idx_d]),
    .seg    (hex_seg)
  );

  // Outputs are computed from next state so the registered values match the state they describe.
  always_comb begin
    blank_mask = lz_blank ? lz_mask(active_d) : '0;
    tick_d     = HAS_BLANK ? (state_d == BLNK && idx_d == 2'd3 && cnt_d == BLANK_LAST)
                           : (state_d == SCAN && idx_d == 2'd3 && cnt_d == DIV_LAST);
    ready_d    = ~tick_d;
    didx_d     = idx_d;
    y_d        = Y_OFF;
    seg_d      = SEG_OFF;
    unique case (state_d)
      SCAN: begin
        y_d   = ~(4'b0001 << idx_d);
        seg_d = blank_mask[idx_d] ? SEG_OFF : hex_seg;
      end
      BLNK:    seg_d = seg_q;
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Aclr) begin
    if (!Aclr) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      cnt_q     <= 16'd0;
      // NOTE: digit registers are reset explicitly so the display powers up at zero, never X.
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      y_q       <= Y_OFF;
      seg_q     <= SEG_OFF;
      didx_q    <= 2'd0;
      tick_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      seg_q     <= seg_d;
      didx_q    <= didx_d;
      tick_q    <= tick_d;
      ready_q   <= ready_d;
    end
  end

  assign Y          = y_q;
  assign seg        = seg_q;
  assign digit_idx  = didx_q;
  assign frame_tick = tick_q;
  assign wr_ready   = ready_q;

endmodule

// File: tb/tb_zjh_scan_ctrl.sv
// Directed bench for zjh_scan_ctrl with DIV=4, BLANK=1 (20-cycle frame).
module tb_zjh_scan_ctrl;

  logic       Clock = 1'b0;
  logic       Aclr = 1'b0;
  logic       en = 1'b0;
  logic       lz_blank = 1'b0;
  logic       wr_valid = 1'b0;
  logic [1:0] wr_addr = 2'd0;
  logic [3:0] wr_data = 4'd0;
  logic       wr_ready;
  logic [3:0] Y;
  logic [6:0] seg;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;
  int pos = 0;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] SA = 7'b1110111;

  always #5 Clock = ~Clock;

  zjh_scan_ctrl #(.DIV(4), .BLANK(1)) dut (
    .Clock      (Clock),
    .Aclr       (Aclr),
    .en         (en),
    .lz_blank   (lz_blank),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .Y          (Y),
    .seg        (seg),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  // One clock; samples land on the falling edge. pos tracks the frame position.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
    pos = (pos + 1) % 20;
  endtask

  task automatic goto(input int p);
    while (pos != p) step();
  endtask

  task automatic start_scan();
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    pos = 0;
  endtask

  task automatic test_reset();
    Aclr = 1'b0;
    en   = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({Y, seg, wr_ready, frame_tick, digit_idx} !== {4'b1111, 7'b0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state: Y=%b seg=%b rdy=%b tick=%b idx=%0d, want Y=1111 seg=0000000 rdy=1 tick=0 idx=0",
               Y, seg, wr_ready, frame_tick, digit_idx);
    end
    Aclr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({Y, seg, wr_ready} !== {4'b1111, 7'b0, 1'b1}) begin
        errors++;
        $display("FAIL idle_cycle%0d: Y=%b seg=%b rdy=%b, want 1111 0000000 1", i, Y, seg, wr_ready);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [3:0] ey;
    logic       et;
    int         slot;
    start_scan();
    for (int i = 0; i < 40; i++) begin
      slot = pos / 5;
      ey   = (pos % 5 == 4) ? 4'b1111 : ~(4'b0001 << slot);
      et   = (pos == 19);
      checks++;
      if ({Y, seg, frame_tick, wr_ready, digit_idx} !== {ey, S0, et, ~et, 2'(slot)}) begin
        errors++;
        $display("FAIL scan_pos%0d: Y=%b seg=%b tick=%b rdy=%b idx=%0d, want Y=%b seg=%b tick=%b rdy=%b idx=%0d",
                 pos, Y, seg, frame_tick, wr_ready, digit_idx, ey, S0, et, ~et, slot);
      end
      step();
    end
  endtask

  task automatic test_write_commit();
    goto(7);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wc_ready: wr_ready=%b want 1", wr_ready);
    end
    wr_valid = 1'b1; wr_addr = 2'd2; wr_data = 4'hA;
    step();
    wr_valid = 1'b0;
    goto(10);
    checks++;
    if ({Y, seg} !== {4'b1011, S0}) begin
      errors++;
      $display("FAIL wc_before_commit: Y=%b seg=%b, want 1011 %b", Y, seg, S0);
    end
    goto(19);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL wc_tick: frame_tick=%b want 1", frame_tick);
    end
    step();
    goto(10);
    checks++;
    if ({Y, seg} !== {4'b1011, SA}) begin
      errors++;
      $display("FAIL wc_after_commit: Y=%b seg=%b, want 1011 %b", Y, seg, SA);
    end
    goto(14);
    checks++;
    if ({Y, seg} !== {4'b1111, SA}) begin
      errors++;
      $display("FAIL wc_blnk_hold: Y=%b seg=%b, want 1111 %b", Y, seg, SA);
    end
  endtask

  task automatic test_boundary_write();
    goto(19);
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 4'h5;
    checks++;
    if ({frame_tick, wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL bw_boundary: tick=%b rdy=%b, want tick=1 rdy=0", frame_tick, wr_ready);
    end
    step();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL bw_next_ready: wr_ready=%b want 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    goto(5);
    checks++;
    if ({Y, seg} !== {4'b1101, S0}) begin
      errors++;
      $display("FAIL bw_same_frame: Y=%b seg=%b, want 1101 %b", Y, seg, S0);
    end
    goto(19);
    step();
    goto(5);
    checks++;
    if ({Y, seg} !== {4'b1101, S5}) begin
      errors++;
      $display("FAIL bw_next_frame: Y=%b seg=%b, want 1101 %b", Y, seg, S5);
    end
  endtask

  task automatic test_lz_blank();
    goto(6);
    wr_valid = 1'b1;
    wr_addr = 2'd1; wr_data = 4'h7; step();
    wr_addr = 2'd1; wr_data = 4'h4; step();
    wr_addr = 2'd2; wr_data = 4'h0; step();
    wr_valid = 1'b0;
    lz_blank = 1'b1;
    // Active digits are still {0,A,5,0}: only digit 3 is a leading zero.
    goto(10);
    checks++;
    if ({Y, seg} !== {4'b1011, SA}) begin
      errors++;
      $display("FAIL lz_old_d2: Y=%b seg=%b, want 1011 %b", Y, seg, SA);
    end
    goto(15);
    checks++;
    if ({Y, seg} !== {4'b0111, 7'b0}) begin
      errors++;
      $display("FAIL lz_old_d3: Y=%b seg=%b, want 0111 0000000", Y, seg);
    end
    goto(19);
    step();
    checks++;
    if ({Y, seg} !== {4'b1110, S0}) begin
      errors++;
      $display("FAIL lz_d0: Y=%b seg=%b, want 1110 %b", Y, seg, S0);
    end
    goto(5);
    checks++;
    if ({Y, seg} !== {4'b1101, S4}) begin
      errors++;
      $display("FAIL lz_d1: Y=%b seg=%b, want 1101 %b", Y, seg, S4);
    end
    goto(10);
    checks++;
    if ({Y, seg} !== {4'b1011, 7'b0}) begin
      errors++;
      $display("FAIL lz_d2: Y=%b seg=%b, want 1011 0000000", Y, seg);
    end
    goto(15);
    checks++;
    if ({Y, seg} !== {4'b0111, 7'b0}) begin
      errors++;
      $display("FAIL lz_d3: Y=%b seg=%b, want 0111 0000000", Y, seg);
    end
    lz_blank = 1'b0;
  endtask

  task automatic test_disable();
    goto(6);
    checks++;
    if (Y !== 4'b1101) begin
      errors++;
      $display("FAIL dis_slot: Y=%b want 1101", Y);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({Y, seg, wr_ready, digit_idx} !== {4'b1111, 7'b0, 1'b1, 2'd0}) begin
        errors++;
        $display("FAIL dis_idle%0d: Y=%b seg=%b rdy=%b idx=%0d, want 1111 0000000 1 0",
                 i, Y, seg, wr_ready, digit_idx);
      end
    end
    en = 1'b1;
    step();
    pos = 0;
    checks++;
    if ({Y, seg, digit_idx} !== {4'b1110, S0, 2'd0}) begin
      errors++;
      $display("FAIL dis_restart: Y=%b seg=%b idx=%0d, want 1110 %b 0", Y, seg, digit_idx, S0);
    end
    goto(5);
    checks++;
    if ({Y, seg} !== {4'b1101, S4}) begin
      errors++;
      $display("FAIL dis_retained_d1: Y=%b seg=%b, want 1101 %b", Y, seg, S4);
    end
    goto(10);
    checks++;
    if ({Y, seg} !== {4'b1011, S0}) begin
      errors++;
      $display("FAIL dis_retained_d2: Y=%b seg=%b, want 1011 %b", Y, seg, S0);
    end
  endtask

  task automatic test_reset_mid();
    goto(6);
    #2;
    Aclr = 1'b0;
    #1;
    checks++;
    if ({Y, seg, wr_ready, frame_tick, digit_idx} !== {4'b1111, 7'b0, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rst_async: Y=%b seg=%b rdy=%b tick=%b idx=%0d, want 1111 0000000 1 0 0",
               Y, seg, wr_ready, frame_tick, digit_idx);
    end
    @(negedge Clock);
    Aclr = 1'b1;
    step();
    pos = 0;
    checks++;
    if ({Y, seg} !== {4'b1110, S0}) begin
      errors++;
      $display("FAIL rst_restart: Y=%b seg=%b, want 1110 %b", Y, seg, S0);
    end
    goto(5);
    checks++;
    if ({Y, seg} !== {4'b1101, S0}) begin
      errors++;
      $display("FAIL rst_cleared_d1: Y=%b seg=%b, want 1101 %b", Y, seg, S0);
    end
    goto(19);
    checks++;
    if ({Y, frame_tick, wr_ready} !== {4'b1111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_tick: Y=%b tick=%b rdy=%b, want 1111 1 0", Y, frame_tick, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_write_commit();
    test_boundary_write();
    test_lz_blank();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
